// File: rtl/alu_arbiter_if.sv
// Two-port request/response bundle for the shared ALU arbiter.
// The master drives requests and response accepts; the slave answers them.
interface alu_arbiter_if #(
    parameter int NBITS = 8
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [NBITS-1:0] req_a0;
    logic [NBITS-1:0] req_b0;
    logic [NBITS-1:0] req_a1;
    logic [NBITS-1:0] req_b1;
    logic [1:0]       req_op0;
    logic [1:0]       req_op1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [NBITS-1:0] rsp_result;
    logic [3:0]       rsp_nzcv;

    modport master (
        output req_valid, req_a0, req_b0, req_a1, req_b1,
        output req_op0, req_op1, rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_nzcv
    );

    modport slave (
        input  req_valid, req_a0, req_b0, req_a1, req_b1,
        input  req_op0, req_op1, rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_nzcv
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two ports sharing one ALU: IDLE accepts, EXEC computes, RESP holds the result.
// Define ALU_ARB_FIXED_PRIO_EN to make port 0 win every tie instead of round-robin.
module alu_arbiter #(
    parameter int NBITS = 8
) (
    input logic          clk,
    input logic          rst_n,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             gnt;
    logic             acc;
    logic             rsp_done;
    logic [NBITS-1:0] a_q;
    logic [NBITS-1:0] b_q;
    logic [1:0]       op_q;
    logic             port_q;
    logic [NBITS-1:0] res_q;
    logic [3:0]       nzcv_q;
    logic [NBITS-1:0] bm;
    logic [NBITS:0]   sum;
    logic [NBITS-1:0] alu_res;
    logic             alu_c;
    logic             alu_v;
`ifndef ALU_ARB_FIXED_PRIO_EN
    logic             last_q;
`endif

    // Port selection: a lone requester wins; a tie goes by priority or pointer.
    always_comb begin
        gnt = 1'b0;
        case (bus.req_valid)
            2'b01:   gnt = 1'b0;
            2'b10:   gnt = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
            2'b11:   gnt = 1'b0;
`else
            2'b11:   gnt = ~last_q;
`endif
            default: gnt = 1'b0;
        endcase
    end

    assign acc      = (state_q == IDLE) & bus.req_valid[gnt];
    assign rsp_done = (state_q == RESP) & bus.rsp_ready[port_q];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic: accept -> EXEC -> RESP -> wait for granted port's accept.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (acc) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state and the current grant.
    always_comb begin
        bus.req_ready = 2'b00;
        bus.rsp_valid = 2'b00;
        if (acc)              bus.req_ready[gnt]    = 1'b1;
        if (state_q == RESP)  bus.rsp_valid[port_q] = 1'b1;
    end

    // Shared ALU on the captured operands; sub is A + ~B + 1.
    always_comb begin
        bm      = op_q[0] ? ~b_q : b_q;
        sum     = {1'b0, a_q} + {1'b0, bm} + {{NBITS{1'b0}}, op_q[0]};
        alu_res = sum[NBITS-1:0];
        alu_c   = sum[NBITS];
        alu_v   = (a_q[NBITS-1] == bm[NBITS-1])
                & (alu_res[NBITS-1] != a_q[NBITS-1]);
        if (op_q[1]) begin
            alu_res = op_q[0] ? (a_q | b_q) : (a_q & b_q);
            alu_c   = 1'b0;
            alu_v   = 1'b0;
        end
    end

    // Operand capture on accept, result/flag capture on EXEC exit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 2'b00;
            port_q <= 1'b0;
            res_q  <= '0;
            nzcv_q <= 4'b0000;
        end else begin
            if (acc) begin
                a_q    <= gnt ? bus.req_a1  : bus.req_a0;
                b_q    <= gnt ? bus.req_b1  : bus.req_b0;
                op_q   <= gnt ? bus.req_op1 : bus.req_op0;
                port_q <= gnt;
            end
            if (state_q == EXEC) begin
                res_q  <= alu_res;
                nzcv_q <= {alu_res[NBITS-1], alu_res == '0, alu_c, alu_v};
            end
        end
    end

`ifndef ALU_ARB_FIXED_PRIO_EN
    // Round-robin pointer remembers the last port accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   last_q <= 1'b1;
        else if (acc) last_q <= gnt;
    end
`endif

    assign bus.rsp_result = res_q;
    assign bus.rsp_nzcv   = nzcv_q;
endmodule
